// File: rtl/sstv_pkg.sv
// Shared SSTV definitions: pixel codes, tone frequencies, receiver bin edges,
// line transmitter FSM states and a small sizing helper.
// Imported by the line transmitter, the pixel tone map and future test generators.
package sstv_pkg;

  // 2-bit grayscale pixel codes
  localparam logic [1:0] PIX_BLACK     = 2'b00;
  localparam logic [1:0] PIX_DARKGRAY  = 2'b01;
  localparam logic [1:0] PIX_LIGHTGRAY = 2'b10;
  localparam logic [1:0] PIX_WHITE     = 2'b11;

  // Tone targets in Hz
  localparam logic [11:0] TONE_SYNC      = 12'd1200;
  localparam logic [11:0] TONE_PORCH     = 12'd1500;
  localparam logic [11:0] TONE_BLACK     = 12'd1600;
  localparam logic [11:0] TONE_DARKGRAY  = 12'd1800;
  localparam logic [11:0] TONE_LIGHTGRAY = 12'd2000;
  localparam logic [11:0] TONE_WHITE     = 12'd2200;

  // Upper edges of the demodulator's color bins; each pixel tone sits
  // 100 Hz below its edge, i.e. in the middle of a 200 Hz bin.
  localparam logic [11:0] BIN_EDGE_BLACK     = 12'd1700;
  localparam logic [11:0] BIN_EDGE_DARKGRAY  = 12'd1900;
  localparam logic [11:0] BIN_EDGE_LIGHTGRAY = 12'd2100;
  localparam logic [11:0] BIN_EDGE_WHITE     = 12'd2300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_PORCH = 2'd2,
    ST_PIXEL = 2'd3
  } tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sstv_pixel_tone.sv
// Combinational pixel code to tone frequency map (bin-centre tones).
// Latency: none (pure combinational). Backpressure: not applicable.
// Ports: code in (2-bit pixel code), freq out (12-bit tone in Hz).
module sstv_pixel_tone
  import sstv_pkg::*;
(
  input  logic [1:0]  code,
  output logic [11:0] freq
);

  always_comb begin
    freq = TONE_BLACK;
    case (code)
      PIX_BLACK:     freq = TONE_BLACK;
      PIX_DARKGRAY:  freq = TONE_DARKGRAY;
      PIX_LIGHTGRAY: freq = TONE_LIGHTGRAY;
      PIX_WHITE:     freq = TONE_WHITE;
      default:       freq = TONE_BLACK;
    endcase
  end

endmodule

// File: rtl/sstv_line_tx.sv
// SSTV scan line transmitter: sync, optional porch, then one tone per pixel slot.
// Latency: start at cycle T gives sync tone at T+1; an accepted pixel drives the next slot.
// Backpressure: pix_ready is high only in the cycle before each slot; no pixel -> black + underrun.
// Ports: clk/reset (sync, active-high); start; pix_data/pix_valid/pix_ready (pixel input);
//        freq (tone in Hz, 0 when silent), tone_en, line_active, line_done, underrun.
// Build option: define SSTV_TX_PORCH_EN to insert the 1500 Hz porch between sync and pixels.
module sstv_line_tx
  import sstv_pkg::*;
#(
  parameter int SYNC_CYCLES  = 64,
  parameter int PORCH_CYCLES = 8,
  parameter int PIXEL_CYCLES = 16,
  parameter int LINE_PIXELS  = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [11:0] freq,
  output logic        tone_en,
  output logic        line_active,
  output logic        line_done,
  output logic        underrun
);

  localparam int CNT_MAX = max3(SYNC_CYCLES, PORCH_CYCLES, PIXEL_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PIXEL_LAST = CNT_W'(PIXEL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LINE_PIXELS - 1);
`ifdef SSTV_TX_PORCH_EN
  localparam logic [CNT_W-1:0] PORCH_LAST = CNT_W'(PORCH_CYCLES - 1);
`endif

  tx_state_t        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [1:0]       pix_q, pix_n;
  logic             slot_start;
  logic             ready_n, done_n, underrun_n, active_n;
  logic [11:0]      pix_tone, freq_n;

  // Next-state and counter logic
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    idx_n      = idx_q;
    pix_n      = pix_q;
    slot_start = 1'b0;
    done_n     = 1'b0;
    underrun_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SYNC;
          cnt_n   = '0;
        end
      end

      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          cnt_n = '0;
`ifdef SSTV_TX_PORCH_EN
          state_n = ST_PORCH;
`else
          state_n    = ST_PIXEL;
          idx_n      = '0;
          slot_start = 1'b1;
`endif
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      ST_PORCH: begin
`ifdef SSTV_TX_PORCH_EN
        if (cnt_q == PORCH_LAST) begin
          state_n    = ST_PIXEL;
          cnt_n      = '0;
          idx_n      = '0;
          slot_start = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
`else
        // Unreachable without the porch; recover to IDLE.
        state_n = ST_IDLE;
        cnt_n   = '0;
`endif
      end

      ST_PIXEL: begin
        if (cnt_q == PIXEL_LAST) begin
          cnt_n = '0;
          if (idx_q == IDX_LAST) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            pix_n   = PIX_BLACK;
          end else begin
            idx_n      = idx_q + IDX_W'(1);
            slot_start = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // A new slot begins exactly where pix_ready was offered; a missing pixel
    // becomes black so the line timing never stalls.
    if (slot_start) begin
      if (pix_ready && pix_valid) begin
        pix_n = pix_data;
      end else begin
        pix_n      = PIX_BLACK;
        underrun_n = 1'b1;
      end
    end
  end

  sstv_pixel_tone u_pixel_tone (
    .code (pix_n),
    .freq (pix_tone)
  );

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    freq_n   = 12'd0;
    active_n = (state_n != ST_IDLE);
    case (state_n)
      ST_SYNC:  freq_n = TONE_SYNC;
      ST_PORCH: freq_n = TONE_PORCH;
      ST_PIXEL: freq_n = pix_tone;
      default:  freq_n = 12'd0;
    endcase

    // Ready in the final cycle before each slot: end of sync/porch for
    // slot 0, end of slots 0..LINE_PIXELS-2 for the rest.
    ready_n = (state_n == ST_PIXEL) && (cnt_n == PIXEL_LAST) && (idx_n != IDX_LAST);
`ifdef SSTV_TX_PORCH_EN
    if ((state_n == ST_PORCH) && (cnt_n == PORCH_LAST)) ready_n = 1'b1;
`else
    if ((state_n == ST_SYNC) && (cnt_n == SYNC_LAST)) ready_n = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pix_q       <= PIX_BLACK;
      pix_ready   <= 1'b0;
      freq        <= 12'd0;
      tone_en     <= 1'b0;
      line_active <= 1'b0;
      line_done   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      idx_q       <= idx_n;
      pix_q       <= pix_n;
      pix_ready   <= ready_n;
      freq        <= freq_n;
      tone_en     <= active_n;
      line_active <= active_n;
      line_done   <= done_n;
      underrun    <= underrun_n;
    end
  end

endmodule
